seq_differencer: RTL and testbench
==================================

# seq_differencer

Inverse of the team's 8-bit sequence adder (running accumulator). Consumes the accumulator's running-sum stream and recovers the per-sample increment, so `diff[n] = sum[n] - sum[n-1]` modulo 2^WIDTH. Also flags wrap-around of the sum and measures how long the step has been constant. Sits downstream of the sequence adder in self-check and loopback paths: adder output feeds `sum_in`, and `diff` must reproduce the adder's `a` input.

## Interface
- `WIDTH`, default 8: width of sum and difference.
- `RUN_W`, default 8: width of the run-length counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state and outputs immediately.
- `clear`, input, 1: synchronous re-arm that returns the block to its post-reset state; mirrors an accumulator restart.
- `in_valid`, input, 1: `sum_in` holds a new accumulator sample this cycle.
- `sum_in`, input, WIDTH: running-sum sample.
- `out_valid`, output, 1: one-cycle pulse; the outputs below carry a new result.
- `diff`, output, WIDTH: recovered increment, unsigned modulo 2^WIDTH.
- `wrap`, output, 1: `sum_in < prev` (unsigned borrow), meaning the accumulator wrapped.
- `step_const`, output, 1: current `diff` equals the previous `diff`.
- `run_len`, output, RUN_W: consecutive samples with the same `diff`; saturates.

## Operation
Internal registers:
- `prev`, WIDTH bits: last accepted sum; reset value 0, matching the accumulator's reset value.
- `last_diff`, WIDTH bits: last produced diff; reset value 0.
- `state`: one of IDLE, ONE, TRACK; reset value IDLE.

State machine, on each accepted sample (`in_valid=1`, `clear=0`):
- IDLE → ONE.
  - `diff = sum_in - 0`.
  - `step_const = 0`, `run_len = 1`.
- ONE → TRACK.
  - `diff = sum_in - prev`.
  - `step_const = (diff == last_diff)`.
  - `run_len = step_const ? 2 : 1`.
- TRACK → TRACK.
  - `diff = sum_in - prev`.
  - If `diff == last_diff`: `step_const = 1` and `run_len = min(run_len + 1, 2^RUN_W - 1)`.
  - Otherwise: `step_const = 0` and `run_len = 1`.

Every accepted sample also updates `prev <= sum_in`, `last_diff <= diff`, `wrap <= (sum_in < prev)`, and `out_valid <= 1`.

Other cases:
- `in_valid=0`: `out_valid <= 0`; all other outputs and internal state hold.
- `clear=1`: `state <= IDLE`, `prev <= 0`, `last_diff <= 0`, all outputs <= 0. `clear` has priority over `in_valid`; a sample presented in the same cycle is discarded.
- Arithmetic:
  - Subtraction is WIDTH-bit unsigned with the borrow discarded.
  - `wrap` carries the borrow only.
  - A difference of 0 (a repeated sum) is legal and produces `diff=0`.

## Timing
- Reset values: `out_valid=0`, `diff=0`, `wrap=0`, `step_const=0`, `run_len=0`. The same values apply after `clear`.
- Latency:
  - A sample accepted at edge N produces results that are visible after edge N.
  - `out_valid` is high for exactly the cycle following edge N.
  - Throughput is one sample per clock.
- Results are registered; there is no combinational path from `sum_in` to any output.
- Assertion of `reset` mid-stream:
  - Outputs go to reset values without waiting for a clock edge.
  - On the first accepted sample after `reset` deasserts, the block behaves as in IDLE.
- The saturated `run_len` holds at `2^RUN_W - 1` and only drops to 1 on a step change.
- `wrap` and `step_const` are independent. A constant step across the wrap gives `wrap=1` and `step_const=1`.

## Test plan
1. **Constant step.**
   - Stimulus: `reset` for 200 ns, then sums 1, 2, 3, 4 with `in_valid=1`.
   - Required: `diff` = 1, 1, 1, 1; `step_const` = 0, 1, 1, 1; `run_len` = 1, 2, 3, 4; `wrap` = 0 throughout.
2. **Wrap-around.**
   - Stimulus: sequence adder (`a=1`) drives `sum_in` through 254, 255, 0, 1.
   - Required: `diff` = 1 on every sample; `wrap` = 1 only on the sample with sum 0; `step_const` stays 1.
3. **Step change.**
   - Stimulus: sums 1, 2, 4, 6, 6 from reset.
   - Required: `diff` = 1, 1, 2, 2, 0; `step_const` = 0, 1, 0, 1, 0; `run_len` = 1, 2, 1, 2, 1.
4. **Saturation and gaps.**
   - Stimulus: 300 samples with step 3, with `in_valid` dropped for 2 cycles every 10th sample.
   - Required: `run_len` reaches 255 and holds; `out_valid` is 0 during each gap and the other outputs are unchanged.
5. **Clear priority.**
   - Stimulus: mid-stream `clear=1` together with `in_valid=1` and `sum_in=50`, then sum 7.
   - Required: no `out_valid` in the clear cycle; the next result is `diff=7`, `run_len=1`, `step_const=0`.
6. **Async reset mid-stream.**
   - Stimulus: assert `reset` between clock edges while `run_len=5`.
   - Required: all outputs are 0 before the next edge; after release, sum 9 yields `diff=9`.

Source files
------------

// File: rtl/seq_differencer.sv
// Recovers the per-sample increment from a running-sum stream (inverse of the sequence adder),
// flags accumulator wrap-around and tracks how long the recovered step has stayed constant.
module seq_differencer #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sum_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             wrap,
  output logic             step_const,
  output logic [RUN_W-1:0] run_len,
  output logic [1:0]       state_dbg
);

  // Handshake: valid-only stream with no backpressure. A sample is accepted on every rising
  // edge where in_valid=1 and clear=0; out_valid pulses for the one cycle after that edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONE   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] last_diff;
  logic [WIDTH-1:0] cur_diff;
  logic             same;
  logic             sc_n;
  logic [RUN_W-1:0] rl_n;

  assign state_dbg = state;

  // In IDLE the reference is the accumulator's reset value, which prev already holds.
  assign cur_diff = (state == IDLE) ? sum_in : (sum_in - prev);
  assign same     = (cur_diff == last_diff);

  always_comb begin
    state_n = state;
    sc_n    = 1'b0;
    rl_n    = run_len;
    case (state)
      IDLE: begin
        state_n = ONE;
        sc_n    = 1'b0;
        rl_n    = RUN_W'(1);
      end
      ONE: begin
        state_n = TRACK;
        sc_n    = same;
        rl_n    = same ? RUN_W'(2) : RUN_W'(1);
      end
      TRACK: begin
        state_n = TRACK;
        sc_n    = same;
        if (!same)                rl_n = RUN_W'(1);
        else if (run_len == RUN_MAX) rl_n = RUN_MAX;
        else                      rl_n = run_len + 1'b1;
      end
      default: begin
        state_n = IDLE;
        sc_n    = 1'b0;
        rl_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      last_diff  <= '0;
      out_valid  <= 1'b0;
      diff       <= '0;
      wrap       <= 1'b0;
      step_const <= 1'b0;
      run_len    <= '0;
    end else if (clear) begin
      // A sample presented alongside clear is dropped, matching an accumulator restart.
      state      <= IDLE;
      prev       <= '0;
      last_diff  <= '0;
      out_valid  <= 1'b0;
      diff       <= '0;
      wrap       <= 1'b0;
      step_const <= 1'b0;
      run_len    <= '0;
    end else if (in_valid) begin
      state      <= state_n;
      prev       <= sum_in;
      last_diff  <= cur_diff;
      out_valid  <= 1'b1;
      diff       <= cur_diff;
      wrap       <= (sum_in < prev);
      step_const <= sc_n;
      run_len    <= rl_n;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_differencer.sv
// Directed self-checking bench for seq_differencer: constant step, wrap, step change,
// saturation with gaps, clear priority and asynchronous reset mid-stream.
module tb_seq_differencer;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] sum_in;
  logic       out_valid;
  logic [7:0] diff;
  logic       wrap;
  logic       step_const;
  logic [7:0] run_len;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  seq_differencer #(.WIDTH(8), .RUN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .sum_in     (sum_in),
    .out_valid  (out_valid),
    .diff       (diff),
    .wrap       (wrap),
    .step_const (step_const),
    .run_len    (run_len),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample, then sample the registered result 1 ns after the edge.
  task automatic send(input logic [7:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    sum_in   = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic w,
                            input logic sc, input logic [7:0] rl);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".diff"}, diff, d);
    chk({tag, ".wrap"}, wrap, w);
    chk({tag, ".step_const"}, step_const, sc);
    chk({tag, ".run_len"}, run_len, rl);
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".diff"}, diff, 0);
    chk({tag, ".wrap"}, wrap, 0);
    chk({tag, ".step_const"}, step_const, 0);
    chk({tag, ".run_len"}, run_len, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    logic [7:0] s, p, rl_exp;
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    sum_in   = '0;
    #200;
    expect_zero("reset");
    chk("reset.state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;

    // Constant step 1
    send(8'd1); expect_out("t1.s0", 8'd1, 1'b0, 1'b0, 8'd1);
    chk("t1.state_one", state_dbg, 1);
    send(8'd2); expect_out("t1.s1", 8'd1, 1'b0, 1'b1, 8'd2);
    send(8'd3); expect_out("t1.s2", 8'd1, 1'b0, 1'b1, 8'd3);
    send(8'd4); expect_out("t1.s3", 8'd1, 1'b0, 1'b1, 8'd4);
    gap();
    chk("t1.gap.out_valid", out_valid, 0);

    // Wrap-around with a running step of 1
    do_clear();
    expect_zero("t2.clear");
    send(8'd252); expect_out("t2.s252", 8'd252, 1'b0, 1'b0, 8'd1);
    send(8'd253); expect_out("t2.s253", 8'd1, 1'b0, 1'b0, 8'd1);
    send(8'd254); expect_out("t2.s254", 8'd1, 1'b0, 1'b1, 8'd2);
    send(8'd255); expect_out("t2.s255", 8'd1, 1'b0, 1'b1, 8'd3);
    send(8'd0);   expect_out("t2.s0",   8'd1, 1'b1, 1'b1, 8'd4);
    send(8'd1);   expect_out("t2.s1",   8'd1, 1'b0, 1'b1, 8'd5);

    // Step change, including a repeated sum
    do_clear();
    send(8'd1); expect_out("t3.s1",  8'd1, 1'b0, 1'b0, 8'd1);
    send(8'd2); expect_out("t3.s2",  8'd1, 1'b0, 1'b1, 8'd2);
    send(8'd4); expect_out("t3.s4",  8'd2, 1'b0, 1'b0, 8'd1);
    send(8'd6); expect_out("t3.s6",  8'd2, 1'b0, 1'b1, 8'd2);
    send(8'd6); expect_out("t3.s6b", 8'd0, 1'b0, 1'b0, 8'd1);

    // Saturation with 2-cycle gaps after every 10th sample
    do_clear();
    p = 8'd0;
    for (int k = 1; k <= 300; k++) begin
      s      = 8'(3 * k);
      rl_exp = (k >= 255) ? 8'd255 : 8'(k);
      send(s);
      expect_out($sformatf("t4.k%0d", k), 8'd3, (s < p), (k > 1), rl_exp);
      p = s;
      if (k % 10 == 0) begin
        for (int g = 0; g < 2; g++) begin
          gap();
          chk($sformatf("t4.gap%0d.out_valid", k), out_valid, 0);
          chk($sformatf("t4.gap%0d.diff", k), diff, 3);
          chk($sformatf("t4.gap%0d.run_len", k), run_len, rl_exp);
          chk($sformatf("t4.gap%0d.step_const", k), step_const, (k > 1));
        end
      end
    end
    chk("t4.saturated", run_len, 255);

    // Clear has priority over a simultaneous sample
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    sum_in   = 8'd50;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    expect_zero("t5.clear");
    chk("t5.state", state_dbg, 0);
    send(8'd7); expect_out("t5.s7", 8'd7, 1'b0, 1'b0, 8'd1);

    // Async reset mid-stream while run_len = 5
    send(8'd9);  expect_out("t6.s9",  8'd2, 1'b0, 1'b0, 8'd1);
    send(8'd11); expect_out("t6.s11", 8'd2, 1'b0, 1'b1, 8'd2);
    send(8'd13); expect_out("t6.s13", 8'd2, 1'b0, 1'b1, 8'd3);
    send(8'd15); expect_out("t6.s15", 8'd2, 1'b0, 1'b1, 8'd4);
    send(8'd17); expect_out("t6.s17", 8'd2, 1'b0, 1'b1, 8'd5);
    #2;
    reset = 1'b1;
    #1;
    expect_zero("t6.async");
    @(negedge clk);
    reset = 1'b0;
    send(8'd9); expect_out("t6.after", 8'd9, 1'b0, 1'b0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
